// File: rtl/aegnn_pkg.sv
// Shared event/time types for the graph-build blocks, plus the time-window test.
// Optional statistics in select_neighbors_multi are enabled with SELECT_NEIGHBORS_STATS_EN.
package aegnn_pkg;

  typedef logic [15:0] time_t;

  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [7:0] y;
    time_t      t;
  } event_s;

  localparam int    MAX_DEGREE = 8;
  localparam time_t MAX_DT     = 16'd100;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_SCAN = 2'd1,
    SEL_DONE = 2'd2
  } sel_state_e;

  // Age is taken modulo 2^16 so windows that straddle the timestamp wrap still match.
  function automatic logic in_window(event_s e, time_t now, time_t win);
    time_t dt;
    dt = now - e.t;
    return e.valid && (dt <= win);
  endfunction

endpackage

// File: rtl/prio_pick_k.sv
// Combinational pick of up to k_max highest set bits of a mask, highest first.
// Returns the picked indices, how many were picked and the mask with them cleared.
module prio_pick_k
  import aegnn_pkg::*;
#(
  parameter int DEGREE = MAX_DEGREE,
  parameter int LANES  = 2,
  parameter int CNT_W  = $clog2(DEGREE) + 1
) (
  input  logic [DEGREE-1:0]         mask,
  input  logic [CNT_W-1:0]          k_max,
  output logic [$clog2(DEGREE)-1:0] idx [LANES],
  output logic [CNT_W-1:0]          cnt,
  output logic [DEGREE-1:0]         mask_out
);

  localparam int IW = $clog2(DEGREE);

  logic [DEGREE-1:0] rem;
  logic              found;
  logic [IW-1:0]     hi;

  always_comb begin
    rem   = mask;
    cnt   = '0;
    found = 1'b0;
    hi    = '0;
    for (int l = 0; l < LANES; l++) begin
      idx[l] = '0;
      found  = 1'b0;
      hi     = '0;
      // Later hits overwrite earlier ones, leaving the highest set index.
      for (int i = 0; i < DEGREE; i++) begin
        if (rem[i]) begin
          found = 1'b1;
          hi    = IW'(i);
        end
      end
      if (found && (CNT_W'(l) < k_max)) begin
        idx[l]  = hi;
        rem[hi] = 1'b0;
        cnt     = cnt + CNT_W'(1);
      end
    end
    mask_out = rem;
  end

endmodule

// File: rtl/select_neighbors_multi.sv
// Multi-lane neighbour selector: snapshots the neighbourhood, filters by validity and
// time window, and pushes up to LANES neighbours per cycle, newest first. Stats: SELECT_NEIGHBORS_STATS_EN.
module select_neighbors_multi
  import aegnn_pkg::*;
#(
  parameter int DEGREE      = MAX_DEGREE,
  parameter int LANES       = 2,
  parameter int FULL_POLICY = 0,
  parameter int CNT_W       = $clog2(DEGREE) + 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       local_buffer_valid,
  input  event_s                     local_buffer [DEGREE],
  output logic                       select_ready,
  output logic                       select_done,
  input  time_t                      t_now,
  input  time_t                      max_dt,
  input  logic [CNT_W-1:0]           max_neighbors,
  output logic [CNT_W-1:0]           nb_count,
  output logic                       dropped,
  output logic                       fifo_wr_en,
  output logic [$clog2(LANES+1)-1:0] fifo_wr_cnt,
  output event_s                     fifo_din [LANES],
  input  logic [$clog2(LANES):0]     fifo_free,
  output sel_state_e                 dbg_state
`ifdef SELECT_NEIGHBORS_STATS_EN
  ,
  output logic [31:0]                stat_events,
  output logic [31:0]                stat_neighbors,
  output logic [31:0]                stat_drops
`endif
);

  // Handshake: an event is taken on a clk edge where select_ready && local_buffer_valid;
  // the FIFO takes exactly fifo_wr_cnt entries on every edge where fifo_wr_en is high.

  localparam int IW   = $clog2(DEGREE);
  localparam int WC_W = $clog2(LANES + 1);

  sel_state_e        state, state_d;
  event_s            snap [DEGREE];
  logic [DEGREE-1:0] pending, pend_d, pend_in, pend_left;
  logic [CNT_W-1:0]  cap, cap_d, nb_d, cap_rem, k_max, pick_cnt;
  logic              drop_d, load;
  logic [IW-1:0]     pick_idx [LANES];

  assign dbg_state = state;

  always_comb begin
    pend_in = '0;
    for (int i = 0; i < DEGREE; i++) begin
      pend_in[i] = in_window(local_buffer[i], t_now, max_dt);
    end
  end

  // Lane budget this cycle; zero outside SCAN and during reset so nothing is written.
  always_comb begin
    cap_rem = (cap == '0) ? CNT_W'(LANES) : (cap - nb_count);
    k_max   = CNT_W'(LANES);
    if (CNT_W'(fifo_free) < k_max) k_max = CNT_W'(fifo_free);
    if (cap_rem < k_max) k_max = cap_rem;
    if ((state != SEL_SCAN) || !rstn) k_max = '0;
  end

  prio_pick_k #(
    .DEGREE (DEGREE),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) u_pick (
    .mask     (pending),
    .k_max    (k_max),
    .idx      (pick_idx),
    .cnt      (pick_cnt),
    .mask_out (pend_left)
  );

  always_comb begin
    fifo_wr_en  = (pick_cnt != '0);
    fifo_wr_cnt = WC_W'(pick_cnt);
    for (int l = 0; l < LANES; l++) begin
      fifo_din[l] = (CNT_W'(l) < pick_cnt) ? snap[pick_idx[l]] : '0;
    end
  end

  always_comb begin
    state_d      = state;
    pend_d       = pending;
    nb_d         = nb_count;
    drop_d       = dropped;
    cap_d        = cap;
    load         = 1'b0;
    select_ready = 1'b0;
    select_done  = 1'b0;
    case (state)
      SEL_IDLE: begin
        select_ready = 1'b1;
        if (local_buffer_valid) begin
          load    = 1'b1;
          pend_d  = pend_in;
          nb_d    = '0;
          drop_d  = 1'b0;
          cap_d   = max_neighbors;
          state_d = (|pend_in) ? SEL_SCAN : SEL_DONE;
        end
      end
      SEL_SCAN: begin
        if (fifo_free == '0) begin
          if (FULL_POLICY == 1) begin
            drop_d  = 1'b1;
            state_d = SEL_DONE;
          end
        end else begin
          pend_d = pend_left;
          nb_d   = nb_count + pick_cnt;
          if ((pend_left == '0) || ((cap != '0) && (nb_d == cap))) state_d = SEL_DONE;
        end
      end
      SEL_DONE: begin
        select_done = 1'b1;
        state_d     = SEL_IDLE;
      end
      default: state_d = SEL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= SEL_IDLE;
      pending  <= '0;
      nb_count <= '0;
      dropped  <= 1'b0;
      cap      <= '0;
    end else begin
      state    <= state_d;
      pending  <= pend_d;
      nb_count <= nb_d;
      dropped  <= drop_d;
      cap      <= cap_d;
    end
  end

  // Snapshot is pure data; it is only read while pending bits qualify it.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEGREE; i++) snap[i] <= local_buffer[i];
    end
  end

`ifdef SELECT_NEIGHBORS_STATS_EN
  logic [32:0] nb_sum;
  assign nb_sum = {1'b0, stat_neighbors} + 33'(pick_cnt);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_events    <= '0;
      stat_neighbors <= '0;
      stat_drops     <= '0;
    end else begin
      if (load && (stat_events != '1)) stat_events <= stat_events + 32'd1;
      if (fifo_wr_en) stat_neighbors <= nb_sum[32] ? '1 : nb_sum[31:0];
      if ((state == SEL_SCAN) && drop_d && (stat_drops != '1)) stat_drops <= stat_drops + 32'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (CNT_W'(fifo_wr_cnt) <= CNT_W'(fifo_free));
      assert (!fifo_wr_en || (state == SEL_SCAN));
    end
  end

endmodule
